cmutex_merge_n_sync: RTL and testbench

- Clocked, parametrised N-way mutual-exclusion merge with drive/free handshake and optional payload.
- Next generation of the 4-input asynchronous mutex merge. Adds:
  - arbitration between simultaneous requests (fixed priority or round robin);
  - per-channel request latching;
  - payload forwarding;
  - error flags.
- Sits in the synchronous islands of the TPU datapath, merging N producer streams into one consumer.
- Each channel holds at most one outstanding token. o_free to the owner is issued only after i_freeNext returns.

---
 rtl/cmutex_merge_n_sync_pkg.sv | 24 ++
 rtl/cmutex_merge_n_sync_arb.sv | 39 +++
 rtl/cmutex_merge_n_sync.sv | 137 +++++++++++++
 tb/tb_cmutex_merge_n_sync.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmutex_merge_n_sync_pkg.sv
// ============================================================================
// cmutex_pkg : shared constants for the clocked mutex merge family
// Rev 1.0
// ============================================================================
`default_nettype none

package cmutex_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam int ERR_OVF  = 0;
  localparam int ERR_SPUR = 1;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmutex_merge_n_sync_arb.sv
// ============================================================================
// rr_arbiter_n : combinational one-hot arbiter, fixed priority or round robin
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter_n
  import cmutex_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int ARB_MODE = ARB_RR,
  localparam int PW       = ptr_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_last,
  output logic [N-1:0]  o_gnt
);

  logic          found;
  logic [PW-1:0] idx;

  // Round robin scans upward from the channel after the last winner and wraps.
  always_comb begin
    o_gnt = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (ARB_MODE == ARB_FIXED) idx = PW'(i);
      else                       idx = PW'((int'(i_last) + 1 + i) % N);
      if (!found && i_req[idx]) begin
        o_gnt[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cmutex_merge_n_sync.sv
// ============================================================================
// cmutex_merge_n_sync : N-way clocked mutex merge with drive/free handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module cmutex_merge_n_sync
  import cmutex_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int DW       = 8,
  parameter  int ARB_MODE = ARB_RR,
  localparam int DWI      = (DW > 0) ? DW : 1,
  localparam int PW       = ptr_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     i_drive,
  input  logic [N*DWI-1:0] i_data,
  output logic [N-1:0]     o_free,
  output logic             o_driveNext,
  output logic [DWI-1:0]   o_dataNext,
  output logic [N-1:0]     o_grant,
  input  logic             i_freeNext,
  output logic [1:0]       o_err
);

  logic [0:0]               state_q, state_d;
  logic [N-1:0]             pending_q, pending_d;
  logic [N-1:0][DWI-1:0]    data_q, data_d;
  logic [N-1:0]             grant_q, grant_d;
  logic [N-1:0]             free_q, free_d;
  logic                     drive_next_q, drive_next_d;
  logic [DWI-1:0]           data_next_q, data_next_d;
  logic [1:0]               err_q, err_d;
  logic [PW-1:0]            last_q, last_d;

  logic [N-1:0]             arb_gnt;
  logic [PW-1:0]            arb_idx;

  rr_arbiter_n #(
    .N        (N),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .i_req  (pending_q),
    .i_last (last_q),
    .o_gnt  (arb_gnt)
  );

  always_comb begin
    arb_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (arb_gnt[k]) arb_idx = PW'(k);
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    data_d       = data_q;
    grant_d      = grant_q;
    free_d       = '0;
    drive_next_d = 1'b0;
    data_next_d  = data_next_q;
    err_d        = err_q;
    last_d       = last_q;

    for (int k = 0; k < N; k++) begin
      if (i_drive[k]) begin
        if (pending_q[k]) begin
          err_d[ERR_OVF] = 1'b1;
        end else begin
          pending_d[k] = 1'b1;
          data_d[k]    = i_data[k*DWI +: DWI];
        end
      end
    end

    // Arbitration looks only at already-latched requests, so a fresh drive
    // always waits one cycle before it can be granted.
    case (state_q)
      ST_IDLE: begin
        if (i_freeNext) err_d[ERR_SPUR] = 1'b1;
        if (|pending_q) begin
          grant_d      = arb_gnt;
          drive_next_d = 1'b1;
          data_next_d  = data_q[arb_idx];
          last_d       = arb_idx;
          state_d      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (i_freeNext) begin
          pending_d = pending_d & ~grant_q;
          free_d    = grant_q;
          grant_d   = '0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // last_q resets to N-1 so the first round-robin search starts at channel 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      data_q       <= '0;
      grant_q      <= '0;
      free_q       <= '0;
      drive_next_q <= 1'b0;
      data_next_q  <= '0;
      err_q        <= '0;
      last_q       <= PW'(N - 1);
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      data_q       <= data_d;
      grant_q      <= grant_d;
      free_q       <= free_d;
      drive_next_q <= drive_next_d;
      data_next_q  <= data_next_d;
      err_q        <= err_d;
      last_q       <= last_d;
    end
  end

  assign o_free      = free_q;
  assign o_driveNext = drive_next_q;
  assign o_dataNext  = data_next_q;
  assign o_grant     = grant_q;
  assign o_err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_cmutex_merge_n_sync.sv
// ============================================================================
// tb_cmutex_merge_n_sync : bench for the mutex merge, RR and fixed instances
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cmutex_merge_n_sync;

  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    drive;
  logic [N*DW-1:0] data;
  logic            free_next;

  logic [N-1:0]  rr_free, rr_grant, fp_free, fp_grant;
  logic          rr_dn, fp_dn;
  logic [DW-1:0] rr_dnext, fp_dnext;
  logic [1:0]    rr_err, fp_err;

  cmutex_merge_n_sync #(.N(N), .DW(DW), .ARB_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .i_drive(drive), .i_data(data),
    .o_free(rr_free), .o_driveNext(rr_dn), .o_dataNext(rr_dnext),
    .o_grant(rr_grant), .i_freeNext(free_next), .o_err(rr_err)
  );

  cmutex_merge_n_sync #(.N(N), .DW(DW), .ARB_MODE(0)) dut_fp (
    .clk(clk), .rst(rst), .i_drive(drive), .i_data(data),
    .o_free(fp_free), .o_driveNext(fp_dn), .o_dataNext(fp_dnext),
    .o_grant(fp_grant), .i_freeNext(free_next), .o_err(fp_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model, one slot per instance: 0 = round robin, 1 = fixed priority.
  logic [N-1:0]  m_pend  [2];
  logic [DW-1:0] m_dat   [2][N];
  int            m_owner [2];
  int            m_last  [2];
  logic          m_dn    [2];
  logic [DW-1:0] m_dnext [2];
  logic [N-1:0]  m_grant [2];
  logic [N-1:0]  m_free  [2];
  logic [1:0]    m_err   [2];

  task automatic model_step(input int m);
    logic [N-1:0] old;
    int g, c;
    if (!rst) begin
      m_pend[m] = '0;
      for (int k = 0; k < N; k++) m_dat[m][k] = '0;
      m_owner[m] = -1;
      m_last[m]  = N - 1;
      m_dn[m]    = 1'b0;
      m_dnext[m] = '0;
      m_grant[m] = '0;
      m_free[m]  = '0;
      m_err[m]   = '0;
      return;
    end
    old        = m_pend[m];
    m_dn[m]    = 1'b0;
    m_free[m]  = '0;
    for (int k = 0; k < N; k++) begin
      if (drive[k]) begin
        if (old[k]) m_err[m][0] = 1'b1;
        else begin
          m_pend[m][k] = 1'b1;
          m_dat[m][k]  = data[k*DW +: DW];
        end
      end
    end
    if (m_owner[m] < 0) begin
      if (free_next) m_err[m][1] = 1'b1;
      g = -1;
      for (int i = 0; i < N; i++) begin
        c = (m == 0) ? (m_last[m] + 1 + i) % N : i;
        if (g < 0 && old[c]) g = c;
      end
      if (g >= 0) begin
        m_owner[m]    = g;
        m_last[m]     = g;
        m_dn[m]       = 1'b1;
        m_dnext[m]    = m_dat[m][g];
        m_grant[m]    = '0;
        m_grant[m][g] = 1'b1;
      end
    end else if (free_next) begin
      m_pend[m][m_owner[m]] = 1'b0;
      m_free[m]             = '0;
      m_free[m][m_owner[m]] = 1'b1;
      m_grant[m]            = '0;
      m_owner[m]            = -1;
    end
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  int log_rr[$];
  int log_fp[$];
  int dlog_rr[$];

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check("rr_drivenext", rr_dn,    m_dn[0]);
    check("rr_grant",     rr_grant, m_grant[0]);
    check("rr_free",      rr_free,  m_free[0]);
    check("rr_err",       rr_err,   m_err[0]);
    check("rr_datanext",  rr_dnext, m_dnext[0]);
    check("fp_drivenext", fp_dn,    m_dn[1]);
    check("fp_grant",     fp_grant, m_grant[1]);
    check("fp_free",      fp_free,  m_free[1]);
    check("fp_err",       fp_err,   m_err[1]);
    check("fp_datanext",  fp_dnext, m_dnext[1]);
    if (rr_dn) begin
      log_rr.push_back(oh2i(rr_grant));
      dlog_rr.push_back(int'(rr_dnext));
    end
    if (fp_dn) log_fp.push_back(oh2i(fp_grant));
  endtask

  task automatic do_reset();
    rst = 1'b0; drive = '0; free_next = 1'b0;
    tick();
    rst = 1'b1;
    log_rr.delete(); log_fp.delete(); dlog_rr.delete();
  endtask

  task automatic wait_grant();
    int t = 0;
    while (!rr_dn && t < 12) begin
      tick();
      t++;
    end
    check("wait_grant_timeout", rr_dn, 1'b1);
  endtask

  task automatic release_tok();
    free_next = 1'b1;
    tick();
    free_next = 1'b0;
  endtask

  typedef struct {
    logic            rst;
    logic [N-1:0]    drive;
    logic [N*DW-1:0] data;
    logic            fn;
    logic            dn;
    logic [N-1:0]    grant;
    logic [N-1:0]    free;
    logic [1:0]      err;
    logic [DW-1:0]   dnext;
  } vec_t;

  vec_t vt[11];

  int exp_rr[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
  int exp_dat[8] = '{'h10, 'h11, 'h12, 'h13, 'h20, 'h21, 'h22, 'h23};
  int exp_fp[3]  = '{2, 0, 1};

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single token, spurious release, overflow while pending (round-robin instance).
    vt[0]  = '{1'b0, 4'b0000, 32'h0,        1'b0, 1'b0, 4'b0000, 4'b0000, 2'b00, 8'h00};
    vt[1]  = '{1'b1, 4'b0001, 32'h0000005A, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'b00, 8'h00};
    vt[2]  = '{1'b1, 4'b0000, 32'h0,        1'b0, 1'b1, 4'b0001, 4'b0000, 2'b00, 8'h5A};
    vt[3]  = '{1'b1, 4'b0000, 32'h0,        1'b0, 1'b0, 4'b0001, 4'b0000, 2'b00, 8'h5A};
    vt[4]  = '{1'b1, 4'b0000, 32'h0,        1'b0, 1'b0, 4'b0001, 4'b0000, 2'b00, 8'h5A};
    vt[5]  = '{1'b1, 4'b0000, 32'h0,        1'b1, 1'b0, 4'b0000, 4'b0001, 2'b00, 8'h5A};
    vt[6]  = '{1'b1, 4'b0000, 32'h0,        1'b0, 1'b0, 4'b0000, 4'b0000, 2'b00, 8'h5A};
    vt[7]  = '{1'b1, 4'b0000, 32'h0,        1'b1, 1'b0, 4'b0000, 4'b0000, 2'b10, 8'h5A};
    vt[8]  = '{1'b1, 4'b0010, 32'h00003300, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'b10, 8'h5A};
    vt[9]  = '{1'b1, 4'b0010, 32'h00004400, 1'b0, 1'b1, 4'b0010, 4'b0000, 2'b11, 8'h33};
    vt[10] = '{1'b1, 4'b0000, 32'h0,        1'b1, 1'b0, 4'b0000, 4'b0010, 2'b11, 8'h33};

    rst = 1'b0; drive = '0; data = '0; free_next = 1'b0;
    for (int i = 0; i < 11; i++) begin
      rst = vt[i].rst; drive = vt[i].drive; data = vt[i].data; free_next = vt[i].fn;
      tick();
      check($sformatf("vec%0d_dn", i),    rr_dn,    vt[i].dn);
      check($sformatf("vec%0d_grant", i), rr_grant, vt[i].grant);
      check($sformatf("vec%0d_free", i),  rr_free,  vt[i].free);
      check($sformatf("vec%0d_err", i),   rr_err,   vt[i].err);
      check($sformatf("vec%0d_dnext", i), rr_dnext, vt[i].dnext);
    end
    drive = '0; free_next = 1'b0;

    // Round-robin contention, two full waves.
    do_reset();
    drive = 4'hF; data = 32'h13121110; tick(); drive = '0;
    for (int j = 0; j < 4; j++) begin wait_grant(); tick(); tick(); release_tok(); end
    drive = 4'hF; data = 32'h23222120; tick(); drive = '0;
    for (int j = 0; j < 4; j++) begin wait_grant(); tick(); tick(); release_tok(); end
    check("rr_wave_count", log_rr.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < log_rr.size()) begin
        check($sformatf("rr_order%0d", i), log_rr[i],  exp_rr[i]);
        check($sformatf("rr_data%0d", i),  dlog_rr[i], exp_dat[i]);
      end
    end

    // Fixed priority: ch2 owns, ch0 then ch1 queue up behind it.
    do_reset();
    drive = 4'b0100; tick(); drive = '0; tick();
    drive = 4'b0001; tick();
    drive = 4'b0010; tick(); drive = '0;
    release_tok(); wait_grant(); release_tok(); wait_grant(); release_tok();
    check("fp_count", log_fp.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < log_fp.size()) check($sformatf("fp_order%0d", i), log_fp[i], exp_fp[i]);

    // Overflow while busy, drive with accepted freeNext, drive in o_free cycle.
    do_reset();
    drive = 4'b0010; data = 32'h00002100; tick(); drive = '0;
    wait_grant();
    check("bnd_first_data", rr_dnext, 8'h21);
    drive = 4'b0010; data = 32'h00002200; tick(); drive = '0;
    check("bnd_ovf_err", rr_err, 2'b01);
    free_next = 1'b1; drive = 4'b0010; data = 32'h00002300; tick();
    free_next = 1'b0; drive = '0;
    check("bnd_free", rr_free, 4'b0010);
    drive = 4'b0010; data = 32'h00002400; tick(); drive = '0;
    wait_grant();
    check("bnd_regrant", rr_grant, 4'b0010);
    check("bnd_regrant_data", rr_dnext, 8'h24);
    release_tok();

    // Reset while ch3 owns the token.
    do_reset();
    drive = 4'b1000; data = 32'h77000000; tick(); drive = '0;
    wait_grant();
    check("rst_pre_grant", rr_grant, 4'b1000);
    rst = 1'b0; tick();
    check("rst_grant", rr_grant, 4'b0000);
    check("rst_err", rr_err, 2'b00);
    check("rst_dnext", rr_dnext, 8'h00);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_free", rr_free, 4'b0000);
    end
    drive = 4'b1001; data = 32'h88000099; tick(); drive = '0;
    wait_grant();
    check("rst_resume_ch0", oh2i(rr_grant), 0);
    release_tok();

    // Randomised traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      for (int k = 0; k < N; k++) drive[k] = ($urandom_range(0, 3) == 0);
      data      = $urandom;
      free_next = ($urandom_range(0, 2) == 0);
      rst       = ($urandom_range(0, 149) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
